// File: rtl/mem_access_unit.sv
// Responder for data-memory accesses: lane steering, load extension,
// datapath stall, alignment checking and bus timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] baddr_q, baddr_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwd_q, bwd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        berr_q, berr_d;

    logic        req;
    logic        legal;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext;

    always_comb begin
        req = mem_read | mem_write;
        legal = 1'b0;
        be_c = 4'b0000;
        wd_c = 32'h0;
        case (size)
            2'b00: begin
                legal = 1'b1;
                be_c = 4'b0001 << addr[1:0];
                wd_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                legal = ~addr[0];
                be_c = 4'b0011 << {addr[1], 1'b0};
                wd_c = {2{wdata[15:0]}};
            end
            2'b11: begin
                legal = (addr[1:0] == 2'b00);
                be_c = 4'b1111;
                wd_c = wdata;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        rbyte = 8'h0;
        case (lane_q)
            2'd0: rbyte = bus_rdata[7:0];
            2'd1: rbyte = bus_rdata[15:8];
            2'd2: rbyte = bus_rdata[23:16];
            default: rbyte = bus_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext = bus_rdata;
        if (size_q == 2'b00)
            ext = uns_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        else if (size_q == 2'b01)
            ext = uns_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        baddr_d = baddr_q;
        lane_d = lane_q;
        size_d = size_q;
        uns_d = uns_q;
        we_d = we_q;
        be_d = be_q;
        bwd_d = bwd_q;
        rdata_d = rdata_q;
        berr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && legal) begin
                    state_d = BUSY;
                    cnt_d = 8'd0;
                    baddr_d = {addr[31:2], 2'b00};
                    lane_d = addr[1:0];
                    size_d = size;
                    uns_d = load_unsigned;
                    we_d = mem_write;
                    be_d = be_c;
                    bwd_d = wd_c;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ack) begin
                    if (!we_q)
                        rdata_d = ext;
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    berr_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 8'd0;
            baddr_q <= 32'h0;
            lane_q <= 2'b00;
            size_q <= 2'b00;
            uns_q <= 1'b0;
            we_q <= 1'b0;
            be_q <= 4'b0000;
            bwd_q <= 32'h0;
            rdata_q <= 32'h0;
            berr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            baddr_q <= baddr_d;
            lane_q <= lane_d;
            size_q <= size_d;
            uns_q <= uns_d;
            we_q <= we_d;
            be_q <= be_d;
            bwd_q <= bwd_d;
            rdata_q <= rdata_d;
            berr_q <= berr_d;
        end
    end

    // A rejected access retires with a zero load result.
    always_comb begin
        bus_req = !reset && (state_q == BUSY);
        misalign_err = !reset && (state_q == IDLE) && req && !legal;
        stall = !reset && ((state_q == BUSY) ||
                ((state_q == IDLE) && req && legal));
        rdata = misalign_err ? 32'h0 : rdata_q;
        bus_err = berr_q;
        bus_we = we_q;
        bus_addr = baddr_q;
        bus_be = be_q;
        bus_wdata = bwd_q;
    end

endmodule
